// File: rtl/audio_src_switch_if.sv
// Handshake and sample bus for audio_src_switch: channel inputs, select request, selected output.
interface audio_src_switch_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [SELW-1:0]      sel_req;
  logic                 sel_val;
  logic                 sel_rdy;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      cur_sel;
  logic                 muted;

  modport master (
    output in_data, sel_req, sel_val,
    input  sel_rdy, out_data, cur_sel, muted
  );

  modport slave (
    input  in_data, sel_req, sel_val,
    output sel_rdy, out_data, cur_sel, muted
  );
endinterface

// File: rtl/audio_src_switch.sv
// Audio source selector: switching channels forces the output to zero for MUTE_CYC cycles
// before the new channel is passed through, avoiding an audible step between sources.
module audio_src_switch #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 8,
  parameter int MUTE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  audio_src_switch_if.slave    bus
);
  localparam int SELW = $clog2(NCH);
  localparam int NPAD = 1 << SELW;
  localparam logic [SELW:0] NCH_W    = (SELW+1)'(NCH);
  localparam logic [7:0]    CNT_INIT = 8'(MUTE_CYC - 1);

  typedef enum logic {ACTIVE = 1'b0, MUTE = 1'b1} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [SELW-1:0]   pend_q;
  logic [SELW-1:0]   cur_sel_q;
  logic [WIDTH-1:0]  out_q;

  // Channel table padded to a power of two so any select index is in range.
  logic [WIDTH-1:0]  chan [NPAD];

  for (genvar i = 0; i < NPAD; i++) begin : g_chan
    if (i < NCH) begin : g_real
      assign chan[i] = bus.in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[i] = '0;
    end
  end

  logic req_switch;
  assign req_switch = bus.sel_val && ({1'b0, bus.sel_req} < NCH_W) && (bus.sel_req != cur_sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACTIVE;
      cnt_q     <= '0;
      pend_q    <= '0;
      cur_sel_q <= '0;
      out_q     <= '0;
    end else begin
      case (state_q)
        ACTIVE: begin
          // Same-channel and out-of-range requests are consumed without effect.
          if (req_switch) begin
            state_q <= MUTE;
            pend_q  <= bus.sel_req;
            cnt_q   <= CNT_INIT;
            out_q   <= '0;
          end else begin
            out_q   <= chan[cur_sel_q];
          end
        end
        MUTE: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
            out_q <= '0;
          end else begin
            state_q   <= ACTIVE;
            cur_sel_q <= pend_q;
            out_q     <= chan[pend_q];
          end
        end
        default: state_q <= ACTIVE;
      endcase
    end
  end

  assign bus.out_data = out_q;
  assign bus.cur_sel  = cur_sel_q;
  assign bus.muted    = (state_q == MUTE);
  assign bus.sel_rdy  = (state_q == ACTIVE);
endmodule

// File: doc/audio_src_switch.md
AUDIO_SRC_SWITCH -- requirements
Module: audio_src_switch

Interface
- REQ-001: Parameter NCH, default 4, SHALL set the number of input channels, legal range 2..16.
- REQ-002: Parameter WIDTH, default 8, SHALL set the sample width per channel in bits.
- REQ-003: Parameter MUTE_CYC, default 4, SHALL set the switch-over mute length in cycles, legal range 1..255.
- REQ-004: Derived SELW = $clog2(NCH) SHALL size all select ports.
- REQ-005: clk, input, 1, SHALL be the single clock; all state updates on rising edge.
- REQ-006: rst, input, 1, SHALL be a synchronous, active-high reset.
- REQ-007: in_data, input, NCH*WIDTH, SHALL carry channel i in bits [i*WIDTH +: WIDTH].
- REQ-008: sel_req, input, SELW, SHALL carry the requested channel index.
- REQ-009: sel_val, input, 1, SHALL mark sel_req valid.
- REQ-010: sel_rdy, output, 1, SHALL mark the block able to accept a request.
- REQ-011: out_data, output, WIDTH, SHALL carry the registered selected sample.
- REQ-012: cur_sel, output, SELW, SHALL carry the currently active channel index.
- REQ-013: muted, output, 1, SHALL be high while the output is forced to zero by a switch-over.

Function
- REQ-014: The FSM SHALL have two states: ACTIVE and MUTE; muted = (state == MUTE); sel_rdy = (state == ACTIVE).
- REQ-015: A request SHALL be accepted on a rising edge only when sel_val && sel_rdy.
- REQ-016: An accepted request with sel_req == cur_sel SHALL be consumed with no state change and no mute.
- REQ-017: An accepted request with sel_req >= NCH SHALL be consumed and discarded; cur_sel and state are unchanged.
- REQ-018: An accepted request with a legal sel_req != cur_sel SHALL latch sel_req into a pending register, load the mute counter with MUTE_CYC-1, and enter MUTE.
- REQ-019: In MUTE with counter > 0, the counter SHALL decrement by 1 per cycle.
- REQ-020: In MUTE with counter == 0, the next edge SHALL return the FSM to ACTIVE and set cur_sel to the pending value.
- REQ-021: out_data SHALL update every edge to in_data[next cur_sel] when the next state is ACTIVE, and to 0 when the next state is MUTE.
- REQ-022: For a request accepted at edge E0, out_data SHALL be 0 after edges E0..E(MUTE_CYC-1) and SHALL be the new channel's sample after edge E(MUTE_CYC); this gives exactly MUTE_CYC zero cycles.
- REQ-023: In ACTIVE, out_data SHALL follow in_data[cur_sel] with exactly one cycle of latency.
- REQ-024: While in MUTE, sel_val SHALL be ignored; the requester holds sel_val/sel_req until sel_rdy is seen high.
- REQ-025: A request presented on the same edge the FSM returns to ACTIVE SHALL NOT be accepted, because sel_rdy is low on that edge.
- REQ-026: Changes to in_data for a non-selected channel SHALL have no effect on any output.

Reset
- REQ-027: While rst is high at an edge, the block SHALL set state = ACTIVE, cur_sel = 0, out_data = 0, the mute counter and pending register to 0, muted = 0 and sel_rdy = 1.
- REQ-028: Reset asserted mid-MUTE SHALL abort the switch-over; the pending channel is dropped and cur_sel = 0.
- REQ-029: On the first edge after rst deasserts, out_data SHALL load in_data[0].

Verification (NCH=4, WIDTH=8, MUTE_CYC=4)
- REQ-030: Reset, then in_data ch0..ch3 = 0x11/0x22/0x33/0x44 -> out_data 0x11 one cycle after reset release; cur_sel = 0; sel_rdy = 1.
- REQ-031: sel_req = 2 with sel_val for one cycle -> muted = 1 and out_data = 0 for exactly 4 cycles, then out_data = 0x33, cur_sel = 2, sel_rdy = 1.
- REQ-032: sel_req = 2 while cur_sel = 2 -> no mute, out_data stays 0x33, sel_rdy stays 1.
- REQ-033: NCH=3 build, sel_req = 3 -> request consumed, cur_sel unchanged, no mute.
- REQ-034: During MUTE, sel_req = 1 held with sel_val -> not accepted until sel_rdy rises; it is then accepted, giving a second 4-cycle mute ending with out_data = 0x22.
- REQ-035: rst pulsed on the 2nd MUTE cycle of a switch 0->3 -> after release cur_sel = 0, out_data = 0x11, muted = 0.
